// File: rtl/gfsk_rx_controller.sv
// GFSK packet receive sequencer: access-address search, header/payload/CRC framing, octet output.
// Optional BLE de-whitening of post-AA bits when GFSK_RX_DEWHITEN_EN is defined.
module gfsk_rx_controller #(
  parameter int unsigned AA_MAX_ERR  = 0,
  parameter int unsigned MAX_PDU_LEN = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_enable,
  input  logic [31:0] access_address,
  input  logic [5:0]  channel_number,
  input  logic        phy_bit,
  input  logic        bit_valid,
  output logic [7:0]  octet,
  output logic        octet_valid,
  output logic        octet_is_crc,
  output logic [7:0]  pdu_length,
  output logic        aa_hit,
  output logic        packet_done,
  output logic        len_error,
  output logic        busy
);

  localparam logic [5:0] AaErrLim  = 6'(AA_MAX_ERR);
  localparam logic [8:0] MaxLenLim = 9'(MAX_PDU_LEN);

  typedef enum logic [1:0] {StIdle, StSearch, StHeader, StPayload} state_e;

  state_e      state_q;
  logic [31:0] aa_sr_q;
  logic [5:0]  fill_q;
  logic [7:0]  byte_sr_q;
  // 12 bits: the longest packet is (255 + 5) * 8 = 2080 bits, beyond an 11-bit range.
  logic [11:0] bit_cnt_q;
  logic [11:0] target_q;

  logic [31:0] aa_sr_next;
  logic [31:0] aa_diff;
  logic [5:0]  aa_dist;
  logic [5:0]  fill_next;
  logic        aa_match;
  logic        data_bit;
  logic [7:0]  byte_next;
  logic [11:0] cnt_next;
  logic        octet_done;
  logic [11:0] len_plus;
  logic [11:0] len_target;
  logic        len_bad;
  logic        crc_zone;

  assign aa_sr_next = {phy_bit, aa_sr_q[31:1]};
  assign aa_diff    = aa_sr_next ^ access_address;
  assign fill_next  = (fill_q == 6'd32) ? fill_q : fill_q + 6'd1;

  always_comb begin
    aa_dist = '0;
    for (int i = 0; i < 32; i++) begin
      aa_dist = aa_dist + {5'd0, aa_diff[i]};
    end
  end

  assign aa_match   = (fill_next == 6'd32) && (aa_dist <= AaErrLim);
  assign byte_next  = {data_bit, byte_sr_q[7:1]};
  assign cnt_next   = bit_cnt_q + 12'd1;
  assign octet_done = (cnt_next[2:0] == 3'd0);
  assign len_plus   = {4'd0, byte_next} + 12'd5;
  assign len_target = {len_plus[8:0], 3'b000};
  assign len_bad    = ({1'b0, byte_next} > MaxLenLim);
  // Last three octets of the frame are CRC; target_q is always >= 40 so no underflow.
  assign crc_zone   = (cnt_next > (target_q - 12'd24));

  assign busy = (state_q == StHeader) || (state_q == StPayload);

`ifdef GFSK_RX_DEWHITEN_EN
  logic [6:0] lfsr_q;
  logic       search_hit;
  logic       frame_bit;

  assign search_hit = rx_enable && bit_valid && (state_q == StSearch) && aa_match;
  assign frame_bit  = rx_enable && bit_valid && busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= '0;
    end else if (search_hit) begin
      lfsr_q <= {channel_number[0], channel_number[1], channel_number[2], channel_number[3],
                 channel_number[4], channel_number[5], 1'b1};
    end else if (frame_bit) begin
      lfsr_q <= {lfsr_q[5:4], lfsr_q[3] ^ lfsr_q[6], lfsr_q[2:0], lfsr_q[6]};
    end
  end

  assign data_bit = phy_bit ^ lfsr_q[6];
`else
  logic unused_channel;
  assign unused_channel = ^channel_number;
  assign data_bit       = phy_bit;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      aa_sr_q      <= '0;
      fill_q       <= '0;
      byte_sr_q    <= '0;
      bit_cnt_q    <= '0;
      target_q     <= '0;
      octet        <= '0;
      octet_valid  <= 1'b0;
      octet_is_crc <= 1'b0;
      pdu_length   <= '0;
      aa_hit       <= 1'b0;
      packet_done  <= 1'b0;
      len_error    <= 1'b0;
    end else begin
      octet_valid  <= 1'b0;
      octet_is_crc <= 1'b0;
      aa_hit       <= 1'b0;
      packet_done  <= 1'b0;
      len_error    <= 1'b0;
      if (!rx_enable) begin
        // Disarm drops everything in flight and returns all outputs to their reset values.
        state_q    <= StIdle;
        aa_sr_q    <= '0;
        fill_q     <= '0;
        byte_sr_q  <= '0;
        bit_cnt_q  <= '0;
        target_q   <= '0;
        octet      <= '0;
        pdu_length <= '0;
      end else begin
        case (state_q)
          StIdle: begin
            state_q <= StSearch;
            fill_q  <= '0;
          end
          StSearch: begin
            if (bit_valid) begin
              aa_sr_q <= aa_sr_next;
              fill_q  <= fill_next;
              if (aa_match) begin
                aa_hit    <= 1'b1;
                state_q   <= StHeader;
                bit_cnt_q <= '0;
                byte_sr_q <= '0;
              end
            end
          end
          StHeader: begin
            if (bit_valid) begin
              byte_sr_q <= byte_next;
              bit_cnt_q <= cnt_next;
              if (octet_done) begin
                octet       <= byte_next;
                octet_valid <= 1'b1;
              end
              if (cnt_next == 12'd16) begin
                pdu_length <= byte_next;
                if (len_bad) begin
                  len_error <= 1'b1;
                  state_q   <= StSearch;
                  fill_q    <= '0;
                end else begin
                  target_q <= len_target;
                  state_q  <= StPayload;
                end
              end
            end
          end
          StPayload: begin
            if (bit_valid) begin
              byte_sr_q <= byte_next;
              bit_cnt_q <= cnt_next;
              if (octet_done) begin
                octet        <= byte_next;
                octet_valid  <= 1'b1;
                octet_is_crc <= crc_zone;
              end
              if (cnt_next == target_q) begin
                packet_done <= 1'b1;
                state_q     <= StSearch;
                fill_q      <= '0;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gfsk_rx_controller.sv
// Self-checking bench for gfsk_rx_controller: AA search table, framing, length error, abort cases.
module tb_gfsk_rx_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_en0, rx_en1;
  logic [31:0] aa;
  logic [5:0]  chan;
  logic        phy_bit, bit_valid;

  logic [7:0] oct0, oct1, len0, len1;
  logic       ov0, ov1, crc0, crc1, hit0, hit1, done0, done1, lerr0, lerr1, busy0, busy1;

  always #5 clk = ~clk;

  gfsk_rx_controller #(.AA_MAX_ERR(0), .MAX_PDU_LEN(255)) dut0 (
    .clk(clk), .rst(rst), .rx_enable(rx_en0), .access_address(aa), .channel_number(chan),
    .phy_bit(phy_bit), .bit_valid(bit_valid), .octet(oct0), .octet_valid(ov0),
    .octet_is_crc(crc0), .pdu_length(len0), .aa_hit(hit0), .packet_done(done0),
    .len_error(lerr0), .busy(busy0)
  );

  gfsk_rx_controller #(.AA_MAX_ERR(1), .MAX_PDU_LEN(37)) dut1 (
    .clk(clk), .rst(rst), .rx_enable(rx_en1), .access_address(aa), .channel_number(chan),
    .phy_bit(phy_bit), .bit_valid(bit_valid), .octet(oct1), .octet_valid(ov1),
    .octet_is_crc(crc1), .pdu_length(len1), .aa_hit(hit1), .packet_done(done1),
    .len_error(lerr1), .busy(busy1)
  );

  typedef struct {
    logic [7:0] oct;
    logic       crc;
    logic       done;
  } exp_t;

  typedef struct {
    int          sel;
    logic [31:0] mask;
    logic        exp_hit;
  } aa_vec_t;

  exp_t       exp_q[$];
  logic [7:0] pkt_q[$];
  aa_vec_t    vecs[6];
  int         total = 0, bad = 0;
  int         nhit0 = 0, nhit1 = 0, ndone = 0, nlerr = 0;
  int         h0, h1, d, l;
  logic [6:0] wl;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  // Output monitor: scoreboard pops on every octet strobe, event pulses are counted.
  task automatic sample();
    exp_t e;
    logic [9:0] got;
    if (ov0 || ov1) begin
      got = ov0 ? {oct0, crc0, done0} : {oct1, crc1, done1};
      if (exp_q.size() == 0) begin
        chk("unexpected_octet", {22'd0, got}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("octet_crc_done", {22'd0, got}, {22'd0, e.oct, e.crc, e.done});
      end
    end
    chk("done_with_octet", {30'd0, done0 & ~ov0, done1 & ~ov1}, 32'd0);
    if (hit0) nhit0++;
    if (hit1) nhit1++;
    if (done0 || done1) ndone++;
    if (lerr0 || lerr1) nlerr++;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    int g;
    g = (gap < 0) ? int'($urandom_range(5, 0)) : gap;
    phy_bit   = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    repeat (g) tick();
  endtask

  task automatic send_aa(input logic [31:0] v, input int gap);
    for (int i = 0; i < 32; i++) send_bit(v[i], gap);
  endtask

  task automatic wreset();
    wl = {chan[0], chan[1], chan[2], chan[3], chan[4], chan[5], 1'b1};
  endtask

  task automatic send_wbit(input logic b, input int gap);
    logic x;
    x = b;
`ifdef GFSK_RX_DEWHITEN_EN
    x  = b ^ wl[6];
    wl = {wl[5:4], wl[3] ^ wl[6], wl[2:0], wl[6]};
`endif
    send_bit(x, gap);
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap);
    for (int i = 0; i < 8; i++) send_wbit(v[i], gap);
  endtask

  task automatic push(input logic [7:0] v, input logic c, input logic dn);
    exp_t e;
    e.oct  = v;
    e.crc  = c;
    e.done = dn;
    exp_q.push_back(e);
  endtask

  // Frame bytes from pkt_q: expectations pushed as each byte is driven.
  task automatic send_pkt(input int gap);
    int n;
    n = pkt_q.size();
    wreset();
    for (int k = 0; k < n; k++) begin
      push(pkt_q[k], k >= n - 3, k == n - 1);
      send_byte(pkt_q[k], gap);
    end
  endtask

  initial begin
    vecs[0] = '{sel: 0, mask: 32'h0000_0000, exp_hit: 1'b1};
    vecs[1] = '{sel: 0, mask: 32'h0000_0020, exp_hit: 1'b0};
    vecs[2] = '{sel: 1, mask: 32'h0000_0080, exp_hit: 1'b1};
    vecs[3] = '{sel: 1, mask: 32'h0010_0008, exp_hit: 1'b0};
    vecs[4] = '{sel: 0, mask: 32'h8000_0000, exp_hit: 1'b0};
    vecs[5] = '{sel: 1, mask: 32'h0000_0000, exp_hit: 1'b1};

    rst = 1'b1; rx_en0 = 1'b0; rx_en1 = 1'b0; aa = 32'h8E89_BED6; chan = 6'd37;
    phy_bit = 1'b0; bit_valid = 1'b0;
    repeat (3) tick();
    chk("reset_dut0", {20'd0, oct0, ov0, crc0, len0, hit0, done0, lerr0, busy0}, 32'd0);
    chk("reset_dut1", {20'd0, oct1, ov1, crc1, len1, hit1, done1, lerr1, busy1}, 32'd0);
    rst = 1'b0;
    tick();

    for (int r = 0; r < 6; r++) begin
      rx_en0 = (vecs[r].sel == 0);
      rx_en1 = (vecs[r].sel == 1);
      tick();
      h0 = nhit0; h1 = nhit1;
      repeat (8) send_bit(1'($urandom_range(1, 0)), 0);
      send_aa(aa ^ vecs[r].mask, 0);
      chk("aa_hit_latency", {31'd0, (vecs[r].sel == 1) ? hit1 : hit0}, {31'd0, vecs[r].exp_hit});
      tick(); tick();
      chk("aa_hit_count", (vecs[r].sel == 1) ? nhit1 - h1 : nhit0 - h0, {31'd0, vecs[r].exp_hit});
      rx_en0 = 1'b0; rx_en1 = 1'b0;
      tick(); tick();
    end

    // All-zero AA: fill counter must gate the hit until 32 bits
    aa = 32'd0; rx_en0 = 1'b1;
    tick();
    h0 = nhit0;
    repeat (31) send_bit(1'b0, 0);
    tick();
    chk("zero_aa_no_early_hit", nhit0 - h0, 32'd0);
    send_bit(1'b0, 0);
    tick();
    chk("zero_aa_hit_at_32", nhit0 - h0, 32'd1);
    rx_en0 = 1'b0; aa = 32'h8E89_BED6;
    tick();

    // Full packet, once back-to-back and once with random gaps
    for (int pass = 0; pass < 2; pass++) begin
      rx_en0 = 1'b1;
      tick();
      d = ndone; h0 = nhit0;
      send_aa(aa, pass == 0 ? 0 : -1);
      pkt_q = '{8'h02, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC};
      send_pkt(pass == 0 ? 0 : -1);
      tick(); tick();
      chk("pkt_queue_drained", exp_q.size(), 32'd0);
      chk("pkt_pdu_length", {24'd0, len0}, 32'd4);
      chk("pkt_busy_after_done", {31'd0, busy0}, 32'd0);
      chk("pkt_done_count", ndone - d, 32'd1);
      send_aa(aa, 0);
      tick(); tick();
      chk("pkt_rehit_after_done", nhit0 - h0, 32'd2);
      rx_en0 = 1'b0;
      tick();
    end

    // Length above MAX_PDU_LEN=37 on dut1
    rx_en1 = 1'b1;
    tick();
    h1 = nhit1; l = nlerr;
    send_aa(aa, 0);
    wreset();
    push(8'h02, 1'b0, 1'b0);
    push(8'hC8, 1'b0, 1'b0);
    send_byte(8'h02, 0);
    send_byte(8'hC8, 0);
    tick(); tick();
    chk("len_error_pulse", nlerr - l, 32'd1);
    chk("len_error_pdu_length", {24'd0, len1}, 32'd200);
    chk("len_error_busy", {31'd0, busy1}, 32'd0);
    send_byte(8'h5A, 0);
    send_byte(8'hA5, 0);
    tick(); tick();
    chk("len_error_queue", exp_q.size(), 32'd0);
    send_aa(aa, 0);
    tick(); tick();
    chk("hit_after_len_error", nhit1 - h1, 32'd2);
    rx_en1 = 1'b0;
    tick();

    // rx_enable drops on the same cycle as the 8th bit of a payload octet
    rx_en0 = 1'b1;
    tick();
    d = ndone;
    send_aa(aa, 0);
    wreset();
    push(8'h02, 1'b0, 1'b0); push(8'h04, 1'b0, 1'b0);
    push(8'h11, 1'b0, 1'b0); push(8'h22, 1'b0, 1'b0);
    send_byte(8'h02, 0); send_byte(8'h04, 0); send_byte(8'h11, 0); send_byte(8'h22, 0);
    for (int i = 0; i < 7; i++) send_wbit(1'(8'h33 >> i), 0);
    rx_en0 = 1'b0;
    send_wbit(1'b0, 0);
    chk("drop_outputs", {20'd0, oct0, ov0, crc0, len0, hit0, done0, lerr0, busy0}, 32'd0);
    repeat (3) tick();
    chk("drop_queue", exp_q.size(), 32'd0);
    chk("drop_no_done", ndone - d, 32'd0);
    rx_en0 = 1'b1;
    tick();
    send_aa(aa, 0);
    pkt_q = '{8'h05, 8'h00, 8'h12, 8'h34, 8'h56};
    send_pkt(-1);
    tick(); tick();
    chk("drop_recover_done", ndone - d, 32'd1);
    chk("drop_recover_queue", exp_q.size(), 32'd0);

    // Reset asserted mid-payload
    d = ndone;
    send_aa(aa, 0);
    wreset();
    push(8'h02, 1'b0, 1'b0); push(8'h04, 1'b0, 1'b0); push(8'h11, 1'b0, 1'b0);
    send_byte(8'h02, 0); send_byte(8'h04, 0); send_byte(8'h11, 0);
    for (int i = 0; i < 3; i++) send_wbit(1'(8'h22 >> i), 0);
    rst = 1'b1;
    tick();
    chk("rst_outputs", {20'd0, oct0, ov0, crc0, len0, hit0, done0, lerr0, busy0}, 32'd0);
    rst = 1'b0;
    tick(); tick();
    chk("rst_queue", exp_q.size(), 32'd0);
    chk("rst_no_done", ndone - d, 32'd0);
    send_aa(aa, 0);
    pkt_q = '{8'h03, 8'h02, 8'h7E, 8'h81, 8'h01, 8'h02, 8'h03};
    send_pkt(-1);
    tick(); tick();
    chk("rst_recover_done", ndone - d, 32'd1);
    chk("rst_recover_pdu_length", {24'd0, len0}, 32'd2);
    chk("rst_recover_queue", exp_q.size(), 32'd0);
    rx_en0 = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
